// File: rtl/wb_cmd_initiator.sv
// Command-to-Wishbone classic initiator: turns one command into 1..256 single-beat
// bus cycles at incrementing word addresses, returning one response per beat.
module wb_cmd_initiator #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t      state, state_d;
  logic [1:0]  rst_sync;
  logic        run;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, cyc_q, cyc_d;
  logic        ready_q, ready_d, rvalid_q, rvalid_d;
  logic        err_q, err_d, last_q, last_d, busy_q, busy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic        timeout_hit;

  // Reset deassertion is pulled through two flops so nothing moves until the second edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run         = rst_sync[1];
  assign timeout_hit = (wait_q == WW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cyc_d    = cyc_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    rdat_d   = rdat_q;
    err_d    = err_q;
    last_d   = last_q;
    busy_d   = busy_q;
    case (state)
      IDLE: begin
        ready_d = run;
        busy_d  = 1'b0;
        if (cmd_valid && ready_q) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_we ? cmd_dat : 32'h0;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          cnt_d   = cmd_len;
          wait_d  = '0;
          cyc_d   = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // ERR dominates ACK; a late ACK on the final wait cycle still counts as success.
        if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rdat_d   = 32'h0;
          err_d    = 1'b1;
          last_d   = 1'b1;
          state_d  = RSP;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rdat_d   = we_q ? 32'h0 : wb_dat_i;
          err_d    = 1'b0;
          last_d   = (cnt_q == 8'd0);
          state_d  = RSP;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          if (last_q) begin
            ready_d = run;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            adr_d   = adr_q + 32'd4;
            cnt_d   = cnt_q - 8'd1;
            wait_d  = '0;
            cyc_d   = 1'b1;
            state_d = BUS;
          end
        end
      end
      default: begin
        cyc_d    = 1'b0;
        rvalid_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      cnt_q    <= '0;
      wait_q   <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdat_q   <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdat_q   <= rdat_d;
      err_q    <= err_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rvalid_q;
  assign rsp_dat   = rdat_q;
  assign rsp_err   = err_q;
  assign rsp_last  = last_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator with a scripted Wishbone target model.
module tb_wb_cmd_initiator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_last;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Target behaviour knobs, written only by the main sequence.
  int          tgt_delay = 1;
  int          tgt_base = 0;
  int          tgt_err_rel = -1;
  int          tgt_hang_rel = -1;
  logic [31:0] tgt_rdata = '0;
  logic        tgt_spurious = 1'b0;

  // Target state and per-beat log, written only by the target process.
  int          tgt_beat = 0;
  int          stb_cnt = 0;
  logic        ack_on = 1'b0;
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic        log_we  [0:63];
  logic [3:0]  log_sel [0:63];

  wb_cmd_initiator #(.TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Target acks tgt_delay cycles after seeing stb; ack is a one-cycle pulse.
  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clock);
      #2;
      if (ack_on) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        ack_on   = 1'b0;
        stb_cnt  = 0;
        tgt_beat++;
      end else if (wb_cyc_o && wb_stb_o) begin
        stb_cnt++;
        if ((tgt_beat - tgt_base) != tgt_hang_rel && stb_cnt >= tgt_delay) begin
          if (tgt_beat < 64) begin
            log_adr[tgt_beat] = wb_adr_o;
            log_dat[tgt_beat] = wb_dat_o;
            log_we[tgt_beat]  = wb_we_o;
            log_sel[tgt_beat] = wb_sel_o;
          end
          wb_ack_i = 1'b1;
          wb_err_i = ((tgt_beat - tgt_base) == tgt_err_rel);
          wb_dat_i = tgt_rdata + 32'(tgt_beat - tgt_base);
          ack_on   = 1'b1;
        end
      end else begin
        stb_cnt  = 0;
        wb_ack_i = tgt_spurious;
        wb_err_i = tgt_spurious;
        wb_dat_i = tgt_spurious ? 32'hFFFF_FFFF : 32'h0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic new_test(input int delay, input int err_rel, input int hang_rel, input logic [31:0] rdata);
    tgt_base     = tgt_beat;
    tgt_delay    = delay;
    tgt_err_rel  = err_rel;
    tgt_hang_rel = hang_rel;
    tgt_rdata    = rdata;
  endtask

  task automatic send_cmd(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                          input logic [3:0] sel, input logic [7:0] len);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_ready_wait: cmd_ready=%b required=1", cmd_ready);
    end
    cmd_adr = adr; cmd_dat = dat; cmd_we = we; cmd_sel = sel; cmd_len = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_wait: rsp_valid=%b required=1", rsp_valid);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({cmd_ready, rsp_valid, wb_cyc_o, wb_stb_o, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got=%b required=00000", {cmd_ready, rsp_valid, wb_cyc_o, wb_stb_o, busy});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, rsp_dat} !== 96'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: adr=%h dat=%h rsp=%h required=0", wb_adr_o, wb_dat_o, rsp_dat);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sync_first_edge: cmd_ready=%b required=0", cmd_ready);
    end
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready_after: cmd_ready=%b required=1", cmd_ready);
    end
  endtask

  task automatic test_single_read();
    bit got;
    new_test(4, -1, -1, 32'hDEAD_BEEF);
    send_cmd(32'h8000_0010, 32'hAAAA_5555, 1'b0, 4'hF, 8'd0);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy, cmd_ready} !== 5'b11010) begin
      errors++;
      $display("[TB] FAIL read_bus_ctrl: cyc,stb,we,busy,ready=%b required=11010", {wb_cyc_o, wb_stb_o, wb_we_o, busy, cmd_ready});
    end
    checks++;
    if (wb_adr_o !== 32'h8000_0010 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read_bus_adr: adr=%h dat=%h required 80000010/0", wb_adr_o, wb_dat_o);
    end
    wait_rsp(got);
    if (!got) return;
    checks++;
    if (rsp_dat !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || rsp_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_rsp: dat=%h err=%b last=%b required DEADBEEF/0/1", rsp_dat, rsp_err, rsp_last);
    end
    handshake();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_done: ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_fill();
    bit got;
    new_test(1, -1, -1, 32'hCAFE_0000);
    send_cmd(32'h8000_0000, 32'h1234_5678, 1'b1, 4'hF, 8'd3);
    for (int b = 0; b < 4; b++) begin
      wait_rsp(got);
      if (!got) return;
      checks++;
      if (rsp_last !== (b == 3) || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
        errors++;
        $display("[TB] FAIL write_rsp beat%0d: last=%b err=%b dat=%h required %0d/0/0", b, rsp_last, rsp_err, rsp_dat, (b == 3));
      end
      handshake();
    end
    checks++;
    if (tgt_beat - tgt_base !== 4) begin
      errors++;
      $display("[TB] FAIL write_beats: got=%0d required=4", tgt_beat - tgt_base);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (log_adr[tgt_base + b] !== 32'h8000_0000 + 32'(4 * b) || log_dat[tgt_base + b] !== 32'h1234_5678 ||
          log_we[tgt_base + b] !== 1'b1 || log_sel[tgt_base + b] !== 4'hF) begin
        errors++;
        $display("[TB] FAIL write_bus beat%0d: adr=%h dat=%h we=%b sel=%h required %h/12345678/1/f", b,
                 log_adr[tgt_base + b], log_dat[tgt_base + b], log_we[tgt_base + b], log_sel[tgt_base + b],
                 32'h8000_0000 + 32'(4 * b));
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    bit stable = 1'b1;
    new_test(2, -1, -1, 32'h0BAD_F00D);
    send_cmd(32'h0000_1000, 32'h0, 1'b0, 4'h3, 8'd1);
    wait_rsp(got);
    if (!got) return;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_dat !== 32'h0BAD_F00D || rsp_last !== 1'b0 || rsp_err !== 1'b0 || wb_cyc_o) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: valid=%b dat=%h cyc=%b required 1/0badf00d/0", rsp_valid, rsp_dat, wb_cyc_o);
    end
    handshake();
    wait_rsp(got);
    if (!got) return;
    checks++;
    if (rsp_dat !== 32'h0BAD_F00E || rsp_last !== 1'b1 || log_adr[tgt_base + 1] !== 32'h0000_1004) begin
      errors++;
      $display("[TB] FAIL backpressure_beat2: dat=%h last=%b adr=%h required 0badf00e/1/00001004", rsp_dat, rsp_last, log_adr[tgt_base + 1]);
    end
    handshake();
  endtask

  task automatic test_error_abort();
    bit got;
    bit quiet = 1'b1;
    new_test(1, 1, -1, 32'h5000_0000);
    send_cmd(32'h2000_0000, 32'h0, 1'b0, 4'hF, 8'd3);
    wait_rsp(got);
    if (!got) return;
    checks++;
    if (rsp_err !== 1'b0 || rsp_last !== 1'b0 || rsp_dat !== 32'h5000_0000) begin
      errors++;
      $display("[TB] FAIL err_beat1: err=%b last=%b dat=%h required 0/0/50000000", rsp_err, rsp_last, rsp_dat);
    end
    handshake();
    wait_rsp(got);
    if (!got) return;
    checks++;
    if (rsp_err !== 1'b1 || rsp_last !== 1'b1 || rsp_dat !== 32'h0) begin
      errors++;
      $display("[TB] FAIL err_beat2: err=%b last=%b dat=%h required 1/1/0", rsp_err, rsp_last, rsp_dat);
    end
    handshake();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_ready: cmd_ready=%b required=1", cmd_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wb_cyc_o || rsp_valid) quiet = 1'b0;
    end
    checks++;
    if (!quiet || tgt_beat - tgt_base !== 2) begin
      errors++;
      $display("[TB] FAIL err_abort: extra activity=%b beats=%0d required 0/2", !quiet, tgt_beat - tgt_base);
    end
  endtask

  task automatic test_timeout_wrap();
    bit got;
    int n = 0;
    new_test(1, -1, 1, 32'h7700_0000);
    send_cmd(32'hFFFF_FFFC, 32'h0, 1'b0, 4'hF, 8'd1);
    wait_rsp(got);
    if (!got) return;
    checks++;
    if (log_adr[tgt_base] !== 32'hFFFF_FFFC || rsp_err !== 1'b0 || rsp_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_beat1: adr=%h err=%b last=%b required fffffffc/0/0", log_adr[tgt_base], rsp_err, rsp_last);
    end
    handshake();
    checks++;
    if (wb_adr_o !== 32'h0000_0000 || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_adr: adr=%h cyc=%b required 00000000/1", wb_adr_o, wb_cyc_o);
    end
    while (wb_cyc_o && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("[TB] FAIL timeout_len: cyc cycles=%0d required=64", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || rsp_dat !== 32'h0) begin
      errors++;
      $display("[TB] FAIL timeout_rsp: valid=%b err=%b last=%b dat=%h required 1/1/1/0", rsp_valid, rsp_err, rsp_last, rsp_dat);
    end
    handshake();
  endtask

  task automatic test_idle_ack();
    bit quiet = 1'b1;
    tgt_spurious = 1'b1;
    tick();
    tgt_spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || busy || !cmd_ready) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("[TB] FAIL idle_ack_ignored: valid=%b busy=%b ready=%b required 0/0/1", rsp_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    bit quiet = 1'b1;
    new_test(3, -1, -1, 32'h0);
    send_cmd(32'h4000_0000, 32'h9999_0000, 1'b1, 4'hC, 8'd7);
    wait_rsp(got);
    if (!got) return;
    handshake();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, busy, cmd_ready} !== 5'b0 || wb_adr_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_drop: cyc,stb,valid,busy,ready=%b adr=%h required 00000/0",
               {wb_cyc_o, wb_stb_o, rsp_valid, busy, cmd_ready}, wb_adr_o);
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || wb_cyc_o) quiet = 1'b0;
    end
    checks++;
    if (!quiet || tgt_beat - tgt_base !== 1) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: activity=%b beats=%0d required 0/1", !quiet, tgt_beat - tgt_base);
    end
    new_test(2, -1, -1, 32'h600D_CAFE);
    send_cmd(32'h0000_0040, 32'h0, 1'b0, 4'hF, 8'd0);
    wait_rsp(got);
    if (!got) return;
    checks++;
    if (rsp_dat !== 32'h600D_CAFE || rsp_last !== 1'b1 || rsp_err !== 1'b0 || log_adr[tgt_base] !== 32'h0000_0040) begin
      errors++;
      $display("[TB] FAIL reset_mid_next: dat=%h last=%b err=%b adr=%h required 600dcafe/1/0/00000040",
               rsp_dat, rsp_last, rsp_err, log_adr[tgt_base]);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_fill();
    test_backpressure();
    test_error_abort();
    test_timeout_wrap();
    test_idle_ack();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_initiator.md
WB_CMD_INITIATOR -- requirements
Module: wb_cmd_initiator

Interface
REQ-001 Parameter: TIMEOUT, default 64, bus cycles a beat may wait for ACK/ERR before being forced to error.
REQ-002 Port: clock  input  1  single clock for all logic.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-005 Port: cmd_adr / cmd_dat  input  32 / 32  start byte address and write data (repeated on every write beat).
REQ-006 Port: cmd_we / cmd_sel / cmd_len  input  1 / 4 / 8  write enable, byte selects, beat count minus one.
REQ-007 Port: rsp_valid / rsp_ready  output / input  1 / 1  per-beat response handshake.
REQ-008 Port: rsp_dat / rsp_err / rsp_last  output  32 / 1 / 1  read data (0 for writes), beat error, final beat of command.
REQ-009 Port: wb_adr_o / wb_dat_o / wb_sel_o  output  32 / 32 / 4  Wishbone initiator address, write data, selects.
REQ-010 Port: wb_cyc_o / wb_stb_o / wb_we_o  output  1 / 1 / 1  Wishbone classic-cycle controls.
REQ-011 Port: wb_dat_i / wb_ack_i / wb_err_i  input  32 / 1 / 1  target read data, acknowledge, error.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States SHALL be IDLE, BUS, RSP; all outputs registered.
REQ-014 IDLE: cmd_ready SHALL be 1; only in IDLE; cmd_valid&&cmd_ready captures adr/dat/we/sel/len, sets beat counter = cmd_len, moves to BUS.
REQ-015 wb_cyc_o and wb_stb_o SHALL rise the cycle after command acceptance and stay high until ACK/ERR/timeout is sampled.
REQ-016 In BUS, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o SHALL be stable; wb_dat_o SHALL be 0 for reads.
REQ-017 On sampling wb_ack_i=1 (wb_err_i=0): cyc/stb deassert next cycle; rsp_dat = wb_dat_i for reads, 0 for writes; rsp_err=0; move to RSP.
REQ-018 On sampling wb_err_i=1 (with or without ACK): treated as error; rsp_err=1, rsp_last=1, rsp_dat=0; remaining beats aborted.
REQ-019 Timeout: a wait counter SHALL clear on entering BUS and increment each BUS cycle; if it reaches TIMEOUT without ACK/ERR, cyc/stb deassert and the beat completes as an error per REQ-018.
REQ-020 RSP: rsp_valid=1, outputs held until rsp_ready=1; rsp_last=1 when beat counter is 0 or rsp_err=1.
REQ-021 On RSP handshake: if rsp_last, go IDLE (cmd_ready=1 next cycle); else address += 4, counter -= 1, go BUS.
REQ-022 Address increment SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-023 Minimum beat period: 1 cycle acceptance/RSP + 1+ BUS cycles; back-to-back beats SHALL have cyc low at least one cycle between them.
REQ-024 ACK/ERR sampled while not in BUS SHALL be ignored.
REQ-025 cmd_len=0 SHALL perform exactly one beat; cmd_len=255 exactly 256 beats.

Reset
REQ-026 reset_n low SHALL immediately force IDLE and all outputs to 0 except cmd_ready (1 after reset release only, 0 while reset_n low).
REQ-027 Reset asserted mid-transfer SHALL drop cyc/stb asynchronously, discard pending beats and responses; no rsp_valid after release until a new command.
REQ-028 Reset release SHALL be synchronized internally so first state change occurs no earlier than the second clock edge after deassertion.

Verification
REQ-029 Single read: cmd adr=0x8000_0010, we=0, len=0; target ACKs 4 cycles after stb with 0xDEAD_BEEF -> one response rsp_dat=0xDEAD_BEEF, rsp_err=0, rsp_last=1.
REQ-030 Write fill: adr=0x8000_0000, dat=0x1234_5678, sel=0xF, len=3 -> four WB writes at 0x...00/04/08/0C, all dat 0x1234_5678, rsp_last only on 4th.
REQ-031 Backpressure: rsp_ready held 0 for 10 cycles during len=1 read -> rsp outputs stable, no second cyc until handshake.
REQ-032 Error abort: len=3 read, wb_err_i on beat 2 (ACK same cycle) -> beat 2 rsp_err=1, rsp_last=1, no beats 3/4, cmd_ready=1 after.
REQ-033 Timeout/wrap: adr=0xFFFF_FFFC len=1, beat 1 ACKed, beat 2 never ACKed -> beat 2 at 0x0000_0000, cyc drops after 64 cycles, rsp_err=1.
REQ-034 Reset mid-burst: reset_n low during BUS of len=7 write -> cyc/stb 0 same cycle, no rsp_valid after release, next command runs normally.
